// File: rtl/riscv_div_unit_if.sv
// rtl/riscv_div_unit_if.sv - request/response bundle between execute stage and the divider
//
// master (execute stage): start, op, dividend, divisor, kill -> ready, busy, valid, result
// slave  (divider)      : the same signals with directions reversed
interface riscv_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             kill;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, dividend, divisor, kill,
        input  ready, busy, valid, result
    );

    modport slave (
        input  start, op, dividend, divisor, kill,
        output ready, busy, valid, result
    );
endinterface

// File: rtl/riscv_div_unit.sv
// rtl/riscv_div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Ports:
//   clk     in   rising-edge clock
//   rstN    in   asynchronous active-low reset
//   div_if  slave modport of riscv_div_unit_if:
//     start/op/dividend/divisor  request, accepted when ready and op is a divide op
//     kill                       flush, forces IDLE on the next edge and suppresses valid
//     ready                      request can be accepted this cycle (IDLE or DONE)
//     busy                       operation in flight (CALC or FIX), stalls the front end
//     valid/result               one-cycle result pulse; result holds until the next FIX
//
// Optional feature: define DIV_EARLY_OUT_EN to resolve divide-by-zero and signed
// overflow at acceptance, skipping CALC (valid in cycle 2 instead of WIDTH+2).
module riscv_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    riscv_div_unit_if.slave  div_if
);
    localparam int CW = $clog2(WIDTH);

    // alu_operation_t encodings of the divide group
    localparam logic [4:0] OP_DIV  = 5'd20;
    localparam logic [4:0] OP_DIVU = 5'd21;
    localparam logic [4:0] OP_REM  = 5'd22;
    localparam logic [4:0] OP_REMU = 5'd23;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             is_rem;
    logic [WIDTH-1:0] result;

    logic             is_div_op;
    logic             signed_op;
    logic             accept;
    logic             ready_c;
    logic             busy_c;
    logic             valid_c;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign is_div_op = (div_if.op == OP_DIV) || (div_if.op == OP_DIVU) ||
                       (div_if.op == OP_REM) || (div_if.op == OP_REMU);
    assign signed_op = (div_if.op == OP_DIV) || (div_if.op == OP_REM);

    assign abs_a = (signed_op && div_if.dividend[WIDTH-1]) ? -div_if.dividend : div_if.dividend;
    assign abs_b = (signed_op && div_if.divisor[WIDTH-1])  ? -div_if.divisor  : div_if.divisor;

`ifdef DIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic div_zero;
    logic overflow;
    logic early_out;
    assign div_zero  = (div_if.divisor == '0);
    assign overflow  = signed_op && (div_if.dividend == INT_MIN) && (div_if.divisor == '1);
    assign early_out = div_zero || overflow;
`endif

    // One restoring step: the W+1-bit subtract keeps the bit shifted out of rem,
    // so a partial remainder of up to 2*divisor-1 is compared correctly.
    assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign trial     = {rem, quo[WIDTH-1]} - {1'b0, dvs};

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
            end
            CALC: begin
                busy_c = 1'b1;
                if (count == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy_c    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                ready_c   = 1'b1;
                valid_c   = !div_if.kill;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (ready_c && div_if.start && is_div_op && !div_if.kill) begin
            accept = 1'b1;
`ifdef DIV_EARLY_OUT_EN
            state_nxt = early_out ? FIX : CALC;
`else
            state_nxt = CALC;
`endif
        end
        if (div_if.kill) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
            result <= '0;
        end else if (accept) begin
            is_rem <= (div_if.op == OP_REM) || (div_if.op == OP_REMU);
            // A zero divisor must yield all ones regardless of the dividend sign,
            // so the quotient is never negated in that case.
            neg_q  <= signed_op && (div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1]) &&
                      (div_if.divisor != '0);
            neg_r  <= signed_op && div_if.dividend[WIDTH-1];
            dvs    <= abs_b;
            rem    <= '0;
            quo    <= abs_a;
            count  <= CW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
            // Preload the magnitudes the iterative datapath would have produced.
            if (div_zero) begin
                quo <= '1;
                rem <= abs_a;
            end else if (overflow) begin
                quo <= INT_MIN;
                rem <= '0;
            end
`endif
        end else if (state == CALC) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_shift;
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            if (count != '0) begin
                count <= count - CW'(1);
            end
        end else if (state == FIX) begin
            result <= is_rem ? r_fix : q_fix;
        end
    end

    assign div_if.ready  = ready_c;
    assign div_if.busy   = busy_c;
    assign div_if.valid  = valid_c;
    assign div_if.result = result;
endmodule

// File: tb/tb_riscv_div_unit.sv
// tb/tb_riscv_div_unit.sv - self-checking bench for riscv_div_unit
module tb_riscv_div_unit;
    localparam logic [4:0]  OP_ADD  = 5'd0;
    localparam logic [4:0]  OP_DIV  = 5'd20;
    localparam logic [4:0]  OP_DIVU = 5'd21;
    localparam logic [4:0]  OP_REM  = 5'd22;
    localparam logic [4:0]  OP_REMU = 5'd23;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam int          LAT     = 34;
`ifdef DIV_EARLY_OUT_EN
    localparam int          EARLY   = 1;
`else
    localparam int          EARLY   = 0;
`endif

    logic clk;
    logic rstN;
    int   cyc;
    int   checks;
    int   errors;

    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];

    riscv_div_unit_if #(.WIDTH(32)) u_if ();

    riscv_div_unit #(.WIDTH(32)) u_dut (
        .clk    (clk),
        .rstN   (rstN),
        .div_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic ovf;
        ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
        case (o)
            OP_DIVU: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: ref_result = (b == 0) ? a : a % b;
            OP_DIV:  ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? INT_MIN : 32'($signed(a) / $signed(b));
            OP_REM:  ref_result = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: ref_result = 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic corner;
        corner = (b == 0) || (((o == OP_DIV) || (o == OP_REM)) && (a == INT_MIN) && (b == 32'hFFFF_FFFF));
        ref_latency = (EARLY == 1 && corner) ? 2 : LAT;
    endfunction

    // Stimulus only: one-cycle start pulse, operands scrambled afterwards.
    task automatic drive_start(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int t0);
        @(posedge clk); #1;
        u_if.start    = 1'b1;
        u_if.op       = o;
        u_if.dividend = a;
        u_if.divisor  = b;
        t0 = cyc;
        @(posedge clk); #1;
        u_if.start    = 1'b0;
        u_if.op       = OP_ADD;
        u_if.dividend = $urandom;
        u_if.divisor  = $urandom;
    endtask

    task automatic test_reset;
        checks++; if (u_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", u_if.ready); end
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
        checks++; if (u_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", u_if.valid); end
        checks++; if (u_if.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", u_if.result); end
    endtask

    task automatic test_ops;
        logic [4:0]  t_op[16];
        logic [31:0] t_a[16];
        logic [31:0] t_b[16];
        int t0, ec, lat;
        logic [31:0] er;
        logic found;
        t_op = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM,
                 OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        t_a  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, INT_MIN, INT_MIN,
                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 0, 0, 0, 0};
        t_b  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0};
        for (int i = 12; i < 16; i++) begin
            t_a[i] = $urandom;
            t_b[i] = $urandom_range(1, 32'h0001_FFFF);
            if (i[0]) t_b[i] = -t_b[i];
        end
        for (int i = 0; i < 16; i++) begin
            lat = ref_latency(t_op[i], t_a[i], t_b[i]);
            drive_start(t_op[i], t_a[i], t_b[i], t0);
            exp_res_q.push_back(ref_result(t_op[i], t_a[i], t_b[i]));
            exp_cyc_q.push_back(t0 + lat);
            checks++;
            if (u_if.busy !== 1'b1 || u_if.ready !== 1'b0) begin
                errors++; $display("FAIL op%0d_busy_cycle1 got busy=%b ready=%b want busy=1 ready=0", i, u_if.busy, u_if.ready);
            end
            found = 1'b0;
            for (int k = 0; k < 80 && !found; k++) begin
                @(negedge clk);
                if (u_if.valid === 1'b1) found = 1'b1;
            end
            er = exp_res_q.pop_front();
            ec = exp_cyc_q.pop_front();
            checks++;
            if (!found) begin
                errors++; $display("FAIL op%0d_timeout got no valid want valid at cycle %0d", i, ec);
            end else begin
                if (u_if.result !== er) begin
                    errors++; $display("FAIL op%0d_result op=%0d a=%h b=%h got %h want %h", i, t_op[i], t_a[i], t_b[i], u_if.result, er);
                end
                checks++;
                if (cyc !== ec) begin
                    errors++; $display("FAIL op%0d_latency got cycle %0d want %0d", i, cyc - t0, ec - t0);
                end
                @(negedge clk);
                checks++;
                if (u_if.valid !== 1'b0) begin
                    errors++; $display("FAIL op%0d_valid_width got valid=%b one cycle later want 0", i, u_if.valid);
                end
            end
        end
    endtask

    task automatic test_kill;
        int t0, t1, ec, nvalid;
        logic [31:0] er;
        logic found;
        drive_start(OP_DIVU, 32'd1000, 32'd3, t0);
        repeat (9) @(posedge clk);
        #1;
        u_if.kill = 1'b1;
        @(negedge clk);
        checks++;
        if (u_if.valid !== 1'b0) begin errors++; $display("FAIL kill_valid_c10 got %b want 0", u_if.valid); end
        @(posedge clk); #1;
        u_if.kill = 1'b0;
        checks++;
        if (u_if.ready !== 1'b1 || u_if.busy !== 1'b0) begin
            errors++; $display("FAIL kill_idle_c11 got ready=%b busy=%b want ready=1 busy=0", u_if.ready, u_if.busy);
        end
        drive_start(OP_DIVU, 32'd77, 32'd5, t1);
        checks++;
        if (t1 !== t0 + 12) begin errors++; $display("FAIL kill_restart_cycle got %0d want %0d", t1 - t0, 12); end
        exp_res_q.push_back(32'd15);
        exp_cyc_q.push_back(t1 + LAT);
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (u_if.valid === 1'b1) found = 1'b1;
        end
        er = exp_res_q.pop_front();
        ec = exp_cyc_q.pop_front();
        checks++;
        if (!found) begin
            errors++; $display("FAIL kill_restart_timeout got no valid want valid at cycle %0d", ec);
        end else begin
            if (cyc !== ec) begin errors++; $display("FAIL kill_restart_latency got cycle %0d want %0d", cyc, ec); end
            checks++;
            if (u_if.result !== er) begin errors++; $display("FAIL kill_restart_result got %h want %h", u_if.result, er); end
        end
        // kill and start together must leave the unit idle
        @(posedge clk); #1;
        u_if.start = 1'b1; u_if.kill = 1'b1; u_if.op = OP_DIVU;
        u_if.dividend = 32'd9; u_if.divisor = 32'd3;
        @(posedge clk); #1;
        u_if.start = 1'b0; u_if.kill = 1'b0;
        checks++;
        if (u_if.busy !== 1'b0 || u_if.ready !== 1'b1) begin
            errors++; $display("FAIL kill_start_same got busy=%b ready=%b want busy=0 ready=1", u_if.busy, u_if.ready);
        end
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (u_if.valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin errors++; $display("FAIL kill_start_same_valid got %0d pulses want 0", nvalid); end
    endtask

    task automatic test_back_to_back;
        int t0, t1, ec, prev_cyc;
        logic [31:0] er;
        logic found;
        drive_start(OP_DIVU, 32'd50, 32'd5, t0);
        exp_res_q.push_back(32'd10);
        exp_cyc_q.push_back(t0 + LAT);
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (u_if.valid === 1'b1) found = 1'b1;
        end
        er = exp_res_q.pop_front();
        ec = exp_cyc_q.pop_front();
        checks++;
        if (!found) begin
            errors++; $display("FAIL b2b_first_timeout got no valid want valid at cycle %0d", ec);
        end else begin
            if (u_if.result !== er || cyc !== ec) begin
                errors++; $display("FAIL b2b_first got result=%h cycle=%0d want result=%h cycle=%0d", u_if.result, cyc, er, ec);
            end
            // issue the next op inside the DONE cycle
            prev_cyc = cyc;
            u_if.start = 1'b1; u_if.op = OP_DIVU;
            u_if.dividend = 32'd1000; u_if.divisor = 32'd10;
            t1 = cyc;
            exp_res_q.push_back(32'd100);
            exp_cyc_q.push_back(t1 + LAT);
            @(posedge clk); #1;
            u_if.start = 1'b0; u_if.op = OP_ADD;
            u_if.dividend = $urandom; u_if.divisor = $urandom;
            checks++;
            if (u_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", u_if.busy); end
            found = 1'b0;
            for (int k = 0; k < 80 && !found; k++) begin
                @(negedge clk);
                if (u_if.valid === 1'b1) found = 1'b1;
            end
            er = exp_res_q.pop_front();
            ec = exp_cyc_q.pop_front();
            checks++;
            if (!found) begin
                errors++; $display("FAIL b2b_second_timeout got no valid want valid at cycle %0d", ec);
            end else begin
                if (u_if.result !== er) begin errors++; $display("FAIL b2b_second_result got %h want %h", u_if.result, er); end
                checks++;
                if (cyc - prev_cyc !== LAT) begin
                    errors++; $display("FAIL b2b_spacing got %0d cycles want %0d", cyc - prev_cyc, LAT);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int t0, nvalid;
        drive_start(OP_DIVU, 32'd12345, 32'd7, t0);
        repeat (19) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checks++;
        if (u_if.busy !== 1'b0 || u_if.valid !== 1'b0 || u_if.result !== 32'h0) begin
            errors++; $display("FAIL reset_mid got busy=%b valid=%b result=%h want 0 0 0", u_if.busy, u_if.valid, u_if.result);
        end
        checks++;
        if (u_if.ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b want 1", u_if.ready); end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b1; u_if.op = OP_ADD;
        u_if.dividend = 32'd3; u_if.divisor = 32'd4;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        checks++;
        if (u_if.ready !== 1'b1 || u_if.busy !== 1'b0) begin
            errors++; $display("FAIL add_ignored got ready=%b busy=%b want ready=1 busy=0", u_if.ready, u_if.busy);
        end
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (u_if.valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin errors++; $display("FAIL reset_add_valid got %0d pulses want 0", nvalid); end
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rstN   = 1'b0;
        u_if.start    = 1'b0;
        u_if.kill     = 1'b0;
        u_if.op       = OP_ADD;
        u_if.dividend = '0;
        u_if.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        test_reset();
        test_ops();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish want finish before 2ms");
        $fatal(1);
    end
endmodule

// File: doc/riscv_div_unit.md
# riscv_div_unit

Iterative multi-cycle divider for the RV32M `DIV`, `DIVU`, `REM` and `REMU` operations.
- Sits in the execute stage beside the single-cycle ALU.
- Accepts operands from the forwarding muxes and a one-hot-free `alu_operation_t` code.
- Holds the pipeline through `busy` while it iterates.
- Returns a 32-bit result to the execute/memory pipeline register with a single-cycle `valid` pulse.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; radix-2, one quotient bit per cycle.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstN`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only when `ready`=1 and `op` is a divide op.
- `op`  in  5  `alu_operation_t`; only `DIV`, `DIVU`, `REM`, `REMU` are accepted.
- `dividend`  in  WIDTH  rs1 value after forwarding.
- `divisor`  in  WIDTH  rs2 value after forwarding.
- `kill`  in  1  pipeline flush; aborts any operation in flight.
- `ready`  out  1  can accept `start` this cycle.
- `busy`  out  1  operation in flight; drives the hazard-unit stall.
- `valid`  out  1  `result` valid, one-cycle pulse.
- `result`  out  WIDTH  quotient or remainder.

## Operation
- FSM states: `IDLE`, `CALC`, `FIX`, `DONE`.
- **IDLE**
  - `ready`=1.
  - On an accepted `start`, latch `op` and the operands, then go to `CALC`.
  - For signed ops, store |dividend| and |divisor|, and latch `neg_q` = sign(a) XOR sign(b) and `neg_r` = sign(a).
  - Clear the remainder register and load `count`=WIDTH-1.
- **CALC**
  - Each cycle, shift {rem, quo} left 1. Trial-subtract the divisor from rem. If the result is non-negative, commit it and set the quotient LSB to 1.
  - Restoring algorithm; the subtractor is WIDTH+1 bits wide so no carry is lost.
  - When `count`=0, go to `FIX`; otherwise decrement `count`.
- **FIX**
  - Apply the sign: two's-complement the quotient if `neg_q`, and the remainder if `neg_r`.
  - Select the quotient for `DIV`/`DIVU`, or the remainder for `REM`/`REMU`.
  - Register the selection into `result`, then go to `DONE`.
- **DONE**
  - `valid`=1 and `ready`=1.
  - An accepted `start` goes to `CALC` (back-to-back operation); otherwise go to `IDLE`.
- Corner cases, produced by the normal datapath and checked by the bench:
  - Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = dividend.
  - Signed overflow (-2^(WIDTH-1) / -1): quotient = 0x80000000; remainder = 0.
- `start` with a non-divide `op` is ignored: no state change, no `valid`.
- `kill` in any state forces `IDLE` on the next edge and suppresses `valid`. `kill` and `start` in the same cycle leave the unit in `IDLE`.
- `result` holds its last value until the next `FIX` or a reset.

## Timing
- Reset values: state=`IDLE`, `ready`=1, `busy`=0, `valid`=0, `result`=0, `count`=0.
- Cycle 0 is the cycle in which `start` is accepted.
  - Cycles 1..WIDTH: `CALC`.
  - Cycle WIDTH+1: `FIX`.
  - Cycle WIDTH+2: `DONE`, `valid`=1.
  - Latency is 34 cycles for WIDTH=32.
- `busy`=1 in `CALC` and `FIX`, i.e. from cycle 1 up to, but not including, the `DONE` cycle. The hazard unit stalls the front end on `busy`.
- `valid` is high for exactly one cycle per completed operation.
- Throughput is one operation per WIDTH+2 cycles when a new `start` is issued in the `DONE` cycle.
- Operands are sampled only at acceptance; input changes during `CALC` have no effect.
- Asserting `rstN` low mid-operation returns all outputs to their reset values immediately, with no `valid`.

## Configuration
- Macro: `DIV_EARLY_OUT_EN`.
- **Defined:** at acceptance, detect divisor==0 or signed overflow.
  - The FSM skips `CALC` and goes directly to `FIX` with the spec-mandated result preloaded.
  - `valid` then rises in cycle 2.
- **Undefined:** every operation takes the full WIDTH+2 cycles. Corner-case results come from the iterative datapath and must be bit-identical to the defined build.

## Test plan
- DIVU 100 / 7, start at cycle 0 -> `valid` at cycle 34, `result`=14; REMU with the same operands -> `result`=2.
- DIV -7 / 2 -> `result`=0xFFFFFFFD (-3); REM -7 / 2 -> `result`=0xFFFFFFFF (-1).
- DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. With `DIV_EARLY_OUT_EN`, `valid` at cycle 2 for all four; without it, at cycle 34.
- `kill` at cycle 10 of a DIVU -> unit is in `IDLE` at cycle 11, `ready`=1, no `valid` pulse ever; a new start at cycle 12 completes normally.
- Back-to-back: DIVU 1000 / 10 is issued with `start` high in the `DONE` cycle of the prior op -> both `valid` pulses are 34 cycles apart and the second `result`=100.
- `rstN` pulsed low at cycle 20 -> `busy`, `valid` and `result` are all 0 at once; `start` with `op`=ADD -> ignored, `ready` stays 1.
